// File: rtl/pa_core_exu_div_ctrl_pkg.sv
// Shared widths, op encodings, FSM states and the prepared-operand bundle
// for the divider issue controller.
package pa_core_exu_div_ctrl_pkg;

  localparam int DATA_BUS_WIDTH = 32;
  localparam int REG_BUS_WIDTH  = 5;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN,
    ST_WB
  } div_state_e;

  // Operands as the unsigned divider wants them, plus the sign fix-ups it applies afterwards
  typedef struct packed {
    logic [DATA_BUS_WIDTH-1:0] data1;
    logic [DATA_BUS_WIDTH-1:0] data2;
    logic                      quot;
    logic                      q_sign;
    logic                      r_sign;
  } div_prep_t;

endpackage

// File: rtl/pa_core_exu_div_ctrl_if.sv
// Divider issue/result bus and register-file write-back request bus,
// seen from the controller (master) and from the divider/arbiter (slave).
interface pa_core_exu_div_ctrl_if;
  import pa_core_exu_div_ctrl_pkg::*;

  logic                      div_start;
  logic [DATA_BUS_WIDTH-1:0] div_data1;
  logic [DATA_BUS_WIDTH-1:0] div_data2;
  logic [REG_BUS_WIDTH-1:0]  div_reg_waddr;
  logic                      div_op;
  logic                      div_q_sign;
  logic                      div_r_sign;
  logic                      div_hold;
  logic [DATA_BUS_WIDTH-1:0] div_data;
  logic                      div_data_vld;

  logic                      wb_req;
  logic [REG_BUS_WIDTH-1:0]  wb_waddr;
  logic [DATA_BUS_WIDTH-1:0] wb_data;
  logic                      wb_grant;

  modport master (
    output div_start, div_data1, div_data2, div_reg_waddr, div_op,
           div_q_sign, div_r_sign, wb_req, wb_waddr, wb_data,
    input  div_hold, div_data, div_data_vld, wb_grant
  );

  modport slave (
    input  div_start, div_data1, div_data2, div_reg_waddr, div_op,
           div_q_sign, div_r_sign, wb_req, wb_waddr, wb_data,
    output div_hold, div_data, div_data_vld, wb_grant
  );

endinterface

// File: rtl/pa_core_exu_div_prep.sv
// Turns raw rs1/rs2 into divider magnitudes and quotient/remainder sign flags.
module pa_core_exu_div_prep
  import pa_core_exu_div_ctrl_pkg::*;
(
  input  logic [1:0]                op_i,
  input  logic [DATA_BUS_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_BUS_WIDTH-1:0] rs2_data_i,
  output div_prep_t                 prep_o
);

  // Divide-by-zero keeps q_sign clear so the divider's all-ones quotient reads as -1
  always_comb begin
    prep_o       = '0;
    prep_o.quot  = ~op_i[1];
    prep_o.data1 = rs1_data_i;
    prep_o.data2 = rs2_data_i;
    if (!op_i[0]) begin
      prep_o.data1  = rs1_data_i[DATA_BUS_WIDTH-1] ? (DATA_BUS_WIDTH'(0) - rs1_data_i) : rs1_data_i;
      prep_o.data2  = rs2_data_i[DATA_BUS_WIDTH-1] ? (DATA_BUS_WIDTH'(0) - rs2_data_i) : rs2_data_i;
      prep_o.q_sign = (rs1_data_i[DATA_BUS_WIDTH-1] ^ rs2_data_i[DATA_BUS_WIDTH-1])
                      & (rs2_data_i != '0);
      prep_o.r_sign = rs1_data_i[DATA_BUS_WIDTH-1];
    end
  end

endmodule

// File: rtl/pa_core_exu_div_ctrl.sv
// Issue-side controller for the iterative divider: accept, start, wait for the
// result pulse, buffer it and request the write port; flushed divides are drained.
module pa_core_exu_div_ctrl
  import pa_core_exu_div_ctrl_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      req_i,
  input  logic [1:0]                op_i,
  input  logic [DATA_BUS_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_BUS_WIDTH-1:0] rs2_data_i,
  input  logic [REG_BUS_WIDTH-1:0]  rd_i,
  input  logic                      flush_i,
  output logic                      ready_o,
  output logic                      busy_o,
  pa_core_exu_div_ctrl_if.master    div_if
);

  div_state_e                state_q, state_d;
  div_prep_t                 prep, opnd_q;
  logic [REG_BUS_WIDTH-1:0]  rd_q;
  logic [REG_BUS_WIDTH-1:0]  wb_waddr_q;
  logic [DATA_BUS_WIDTH-1:0] wb_data_q;
  logic                      accept;
  logic                      capture;
  logic                      unused_div_hold;

  pa_core_exu_div_prep u_prep (
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .prep_o     (prep)
  );

  assign accept          = (state_q == ST_IDLE) && req_i && !flush_i;
  assign capture         = (state_q == ST_WAIT) && div_if.div_data_vld && !flush_i && (rd_q != '0);
  assign unused_div_hold = div_if.div_hold;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // A started divide cannot be cancelled, so flushes route through DRAIN until its pulse
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = flush_i ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (div_if.div_data_vld) state_d = capture ? ST_WB : ST_IDLE;
        else if (flush_i)        state_d = ST_DRAIN;
      end
      ST_DRAIN: if (div_if.div_data_vld) state_d = ST_IDLE;
      ST_WB:    if (div_if.wb_grant || flush_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      opnd_q <= '0;
      rd_q   <= '0;
    end else if (accept) begin
      opnd_q <= prep;
      rd_q   <= rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_waddr_q <= '0;
      wb_data_q  <= '0;
    end else if (capture) begin
      wb_waddr_q <= rd_q;
      wb_data_q  <= div_if.div_data;
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign busy_o  = !ready_o || accept;

  assign div_if.div_start     = (state_q == ST_ISSUE);
  assign div_if.div_data1     = opnd_q.data1;
  assign div_if.div_data2     = opnd_q.data2;
  assign div_if.div_reg_waddr = rd_q;
  assign div_if.div_op        = opnd_q.quot;
  assign div_if.div_q_sign    = opnd_q.q_sign;
  assign div_if.div_r_sign    = opnd_q.r_sign;

  assign div_if.wb_req   = (state_q == ST_WB);
  assign div_if.wb_waddr = wb_waddr_q;
  assign div_if.wb_data  = wb_data_q;

endmodule

// File: tb/tb_pa_core_exu_div_ctrl.sv
// Randomized bench for the divider controller: plays the divider and the write
// arbiter, and checks every cycle against RISC-V division semantics.
module tb_pa_core_exu_div_ctrl;
  import pa_core_exu_div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd;
  logic        flush;
  logic        ready;
  logic        busy;

  int checkCount = 0;
  int errorCount = 0;

  int          divCount;
  logic [31:0] divRes;

  logic [31:0] corners [8] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'h7, 32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'h2};

  pa_core_exu_div_ctrl_if dif ();

  pa_core_exu_div_ctrl dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_i      (req),
    .op_i       (op),
    .rs1_data_i (rs1),
    .rs2_data_i (rs2),
    .rd_i       (rd),
    .flush_i    (flush),
    .ready_o    (ready),
    .busy_o     (busy),
    .div_if     (dif)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Architectural result of DIV/DIVU/REM/REMU including the zero and overflow cases
  function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (o)
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      OP_REM:  return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic logic [31:0] magnitude(input bit isSigned, input logic [31:0] v);
    longint lv;
    lv = isSigned ? longint'($signed(v)) : longint'(v);
    if (lv < 0) lv = -lv;
    return lv[31:0];
  endfunction

  // Divider stand-in: fast answer for zero or oversized divisors, 33 cycles otherwise
  initial begin
    logic [31:0] d1, d2, q, r;
    dif.div_data_vld = 1'b0;
    dif.div_data     = '0;
    dif.div_hold     = 1'b0;
    divCount         = 0;
    forever begin
      @(negedge clk);
      dif.div_data_vld = 1'b0;
      if (!rst_n) begin
        divCount     = 0;
        dif.div_hold = 1'b0;
      end else if (dif.div_start) begin
        d1 = dif.div_data1;
        d2 = dif.div_data2;
        if (d2 == 0) begin q = 32'hFFFF_FFFF; r = d1; end
        else begin q = d1 / d2; r = d1 % d2; end
        if (dif.div_op) divRes = dif.div_q_sign ? (32'd0 - q) : q;
        else            divRes = dif.div_r_sign ? (32'd0 - r) : r;
        divCount     = (d2 == 0 || d2 > d1) ? 1 : 33;
        dif.div_hold = 1'b1;
      end else if (divCount > 0) begin
        divCount--;
        if (divCount == 0) begin
          dif.div_data_vld = 1'b1;
          dif.div_data     = divRes;
          dif.div_hold     = 1'b0;
        end
      end
    end
  end

  // One transaction; wbFlush: 0 plain grant, 1 flush instead of grant, 2 flush with grant
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] d, input int flushAtIn, input int grantDelay,
                               input int wbFlush, input bit strayReq);
    bit          isSigned, hasWb, expWb;
    logic [31:0] m1, m2, expRes;
    int          vldIdx, wbStart, grantIdx, readyIdx, flushAt;
    isSigned = !o[0];
    m1       = magnitude(isSigned, a);
    m2       = magnitude(isSigned, b);
    expRes   = refResult(o, a, b);
    vldIdx   = (m2 == 0 || m2 > m1) ? 1 : 33;
    wbStart  = vldIdx + 1;
    flushAt  = (flushAtIn > vldIdx) ? vldIdx : flushAtIn;
    hasWb    = (flushAt < 0) && (d != 0);
    grantIdx = wbStart + grantDelay;
    readyIdx = hasWb ? grantIdx + 1 : vldIdx + 1;

    @(negedge clk);
    req = 1'b1; op = o; rs1 = a; rs2 = b; rd = d; flush = 1'b0;
    #1;
    checkOutput("accept_ready", 32'(ready), 32'd1);
    checkOutput("accept_busy", 32'(busy), 32'd1);

    for (int i = 0; i <= readyIdx; i++) begin
      @(negedge clk);
      req          = strayReq && (i < readyIdx);
      op           = 2'($urandom_range(0, 3));
      rs1          = $urandom;
      rs2          = $urandom;
      rd           = 5'($urandom_range(0, 31));
      dif.wb_grant = hasWb && (i == grantIdx) && (wbFlush != 1);
      flush        = (i == flushAt) || (hasWb && i == grantIdx && wbFlush != 0);
      #1;
      expWb = hasWb && (i >= wbStart) && (i <= grantIdx);
      checkOutput("div_start", 32'(dif.div_start), 32'(i == 0));
      checkOutput("ready", 32'(ready), 32'(i == readyIdx));
      checkOutput("busy", 32'(busy), 32'(i != readyIdx));
      checkOutput("wb_req", 32'(dif.wb_req), 32'(expWb));
      if (expWb) begin
        checkOutput("wb_waddr", 32'(dif.wb_waddr), 32'(d));
        checkOutput("wb_data", dif.wb_data, expRes);
      end
      if (i == 0) begin
        checkOutput("div_data1", dif.div_data1, m1);
        checkOutput("div_data2", dif.div_data2, m2);
        checkOutput("div_op", 32'(dif.div_op), 32'(!o[1]));
        checkOutput("div_q_sign", 32'(dif.div_q_sign),
                    32'(isSigned && ($signed(a) < 0) != ($signed(b) < 0) && b != 0));
        checkOutput("div_r_sign", 32'(dif.div_r_sign), 32'(isSigned && $signed(a) < 0));
        checkOutput("div_reg_waddr", 32'(dif.div_reg_waddr), 32'(d));
      end
    end
    dif.wb_grant = 1'b0;
    flush        = 1'b0;
    req          = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_start"}, 32'(dif.div_start), 32'd0);
    checkOutput({tag, "_data1"}, dif.div_data1, 32'd0);
    checkOutput({tag, "_data2"}, dif.div_data2, 32'd0);
    checkOutput({tag, "_raddr"}, 32'(dif.div_reg_waddr), 32'd0);
    checkOutput({tag, "_signs"}, 32'({dif.div_op, dif.div_q_sign, dif.div_r_sign}), 32'd0);
    checkOutput({tag, "_wb_req"}, 32'(dif.wb_req), 32'd0);
    checkOutput({tag, "_wb_waddr"}, 32'(dif.wb_waddr), 32'd0);
    checkOutput({tag, "_wb_data"}, dif.wb_data, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [4:0]  d;
    int          mode;
    rst_n = 1'b0; req = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0; flush = 1'b0;
    dif.wb_grant = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;

    applyStimulus(OP_DIV,  32'd100,          32'd7,           5'd5,  -1, 0, 0, 1'b0);
    applyStimulus(OP_REM,  32'hFFFF_FFF9,    32'd2,           5'd6,  -1, 1, 0, 1'b0);
    applyStimulus(OP_DIV,  32'h8000_0000,    32'hFFFF_FFFF,   5'd7,  -1, 0, 0, 1'b0);
    applyStimulus(OP_REM,  32'h8000_0000,    32'hFFFF_FFFF,   5'd8,  -1, 0, 0, 1'b0);
    applyStimulus(OP_DIVU, 32'd12345,        32'd0,           5'd9,  -1, 0, 0, 1'b0);
    applyStimulus(OP_REM,  32'hFFFF_FFF9,    32'd0,           5'd10, -1, 0, 0, 1'b0);
    applyStimulus(OP_DIV,  32'd1000,         32'd3,           5'd11, 10, 0, 0, 1'b1);
    applyStimulus(OP_DIVU, 32'd1000,         32'd3,           5'd12, 33, 0, 0, 1'b0);
    applyStimulus(OP_DIV,  32'd50,           32'd9,           5'd13, 0,  0, 0, 1'b1);
    applyStimulus(OP_REMU, 32'd77,           32'd10,          5'd14, -1, 5, 0, 1'b1);
    applyStimulus(OP_DIV,  32'd77,           32'd10,          5'd15, -1, 2, 2, 1'b0);
    applyStimulus(OP_DIV,  32'd77,           32'd10,          5'd16, -1, 1, 1, 1'b1);
    applyStimulus(OP_DIV,  32'd77,           32'd10,          5'd0,  -1, 0, 0, 1'b0);

    // Reset in the middle of a long divide
    @(negedge clk);
    req = 1'b1; op = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3; rd = 5'd9;
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_DIVU, 32'd9, 32'd3, 5'd4, -1, 0, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 7)] :
          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      b = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 7)] :
          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mode = $urandom_range(0, 9);
      case (mode)
        6:       applyStimulus(o, a, b, d, $urandom_range(0, 33), 0, 0, 1'($urandom_range(0, 1)));
        7:       applyStimulus(o, a, b, d, -1, $urandom_range(0, 4), 1, 1'b0);
        8:       applyStimulus(o, a, b, d, -1, $urandom_range(0, 4), 2, 1'b1);
        9:       applyStimulus(o, a, b, d, -1, $urandom_range(0, 5), 0, 1'b1);
        default: applyStimulus(o, a, b, d, -1, $urandom_range(0, 3), 0, 1'b0);
      endcase
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pa_core_exu_div_ctrl.md
Name: pa_core_exu_div_ctrl

Overview:
Issue-side controller for the iterative divider (pa_core_exu_div). It accepts DIV/DIVU/REM/REMU from the EXU dispatch and converts signed operands to magnitudes plus quotient/remainder sign flags. It fires the divider start pulse, stalls the pipeline until the divider's one-cycle result-valid pulse, then buffers the result and arbitrates for the register-file write port. It also absorbs pipeline flushes: an in-flight divide cannot be aborted, so it is drained and its result discarded.

Parameters:
None. Widths come from `DATA_BUS_WIDTH (32) and `REG_BUS_WIDTH (5) in pa_chip_param.v.

Ports:
clk_i  in  1  core clock
rst_n_i  in  1  reset, asynchronous, active-low
req_i  in  1  divide instruction valid at EXU
op_i  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1_data_i  in  32  dividend (raw register value)
rs2_data_i  in  32  divisor (raw register value)
rd_i  in  5  destination register
flush_i  in  1  pipeline flush/kill
ready_o  out  1  controller idle; req_i accepted this cycle
busy_o  out  1  stall request to pipeline
div_start_o  out  1  one-cycle start pulse to divider
div_data1_o  out  32  dividend magnitude
div_data2_o  out  32  divisor magnitude
div_reg_waddr_o  out  5  rd forwarded to divider
div_op_o  out  1  1 = quotient, 0 = remainder
div_q_sign_o  out  1  negate quotient
div_r_sign_o  out  1  negate remainder
div_hold_i  in  1  divider busy (monitor only; no control use)
div_data_i  in  32  divider result
div_data_vld_i  in  1  divider result pulse (exactly one cycle)
wb_req_o  out  1  write-back request
wb_waddr_o  out  5  write-back address
wb_data_o  out  32  write-back data
wb_grant_i  in  1  write port granted this cycle

Behaviour:
- States: IDLE, ISSUE, WAIT, DRAIN, WB. Reset enters IDLE. All outputs are registered or decoded from state. Reset value of every output is 0, except ready_o = 1.
- ready_o = (state == IDLE). busy_o = (state != IDLE) or (req_i and IDLE and not flush_i).
- IDLE: when req_i and not flush_i, the request is accepted.
  - Register the operand magnitudes, signs, op and rd.
  - Go to ISSUE.
  - If req_i and flush_i arrive together, the request is ignored.
- Operand preparation for signed ops (op_i[0] = 0):
  - data1 = rs1[31] ? -rs1 : rs1; data2 = rs2[31] ? -rs2 : rs2 (32-bit two's complement).
  - q_sign = (rs1[31] xor rs2[31]) and (rs2 != 0).
  - r_sign = rs1[31].
- Operand preparation for unsigned ops: data1 = rs1, data2 = rs2, both signs 0.
- div_op_o = not op[1].
- Corner results follow from this preparation without special-casing:
  - Signed -2^31 / -1 yields 0x8000_0000 (remainder 0).
  - Divide by zero yields quotient 0xFFFF_FFFF and remainder = rs1.
- ISSUE (exactly one cycle): div_start_o = 1 with stable operands. Next state is WAIT, or DRAIN if flush_i.
  - div_start_o is never asserted outside ISSUE. This is mandatory because the divider restarts on any start pulse.
- WAIT:
  - div_data_vld_i and not flush_i: capture div_data_i and rd into the WB buffer; go to WB.
  - div_data_vld_i and flush_i: go to IDLE, result discarded.
  - flush_i alone: go to DRAIN.
  - If the captured rd == 0, skip WB and go to IDLE.
- DRAIN: wait for div_data_vld_i, then go to IDLE. No wb_req_o. flush_i is ignored. New requests are not accepted.
- WB: wb_req_o = 1, with wb_waddr_o/wb_data_o held stable until wb_grant_i.
  - wb_grant_i: go to IDLE. Grant wins over a simultaneous flush_i.
  - flush_i without grant: go to IDLE, request dropped.
- Latency, measured from the accept cycle T: start in T+1.
  - Normal path: divider vld at T+34, wb_req_o from T+35.
  - Shortcut path (divisor 0 or divisor > dividend): vld at T+2, wb_req_o from T+3.
  - The controller must not rely on either count; it waits on vld only.
- Asynchronous reset mid-operation returns the controller to IDLE. The divider is reset by the same rst_n_i.

Decomposition:
- Op encodings (DIV/DIVU/REM/REMU) and the state encoding are added as `define constants in pa_chip_param.v.
- One combinational sub-module, pa_core_exu_div_prep, performs magnitude and sign generation from op/rs1/rs2. The FSM and buffers stay in the top module.

Test Plan:
- DIV rs1=100, rs2=7, rd=5 -> div_start at T+1; wb_req at T+35 with waddr 5, data 14; after grant, ready_o=1.
- REM rs1=0xFFFF_FFF9 (-7), rs2=2 -> data1=7, r_sign=1; wb_data 0xFFFF_FFFF (-1).
- DIV rs1=0x8000_0000, rs2=0xFFFF_FFFF -> wb_data 0x8000_0000. DIVU x/0 -> wb_data 0xFFFF_FFFF via shortcut at T+3. REM -7/0 -> wb_data 0xFFFF_FFF9.
- flush_i in WAIT cycle 10 -> DRAIN, req_i ignored (ready_o=0), no wb_req at vld, IDLE next cycle.
- wb_grant_i held low 5 cycles -> wb_req/addr/data stable; a concurrent req_i is not accepted; grant together with flush -> write occurs.
- rst_n_i asserted during WAIT -> all outputs 0, ready_o=1 immediately; new DIVU 9/3 after release -> 3.
